// File: rtl/rs_multi_if.sv
// rs_multi_if: decoder insert port, CDB snoop channels and the ALU issue port
// of the reservation station, grouped so the station and its neighbours share
// one bundle.
//   master: decoder / CDB producers / ALU side
//   slave : reservation station side
interface rs_multi_if #(
    parameter int DEPTH   = 8,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // decoder insert port
    logic                     dec_valid;
    logic [4:0]               dec_type;
    logic [31:0]              dec_vj;
    logic [31:0]              dec_vk;
    logic                     dec_has_dep_j;
    logic                     dec_has_dep_k;
    logic [ROB_W-1:0]         dec_dep_j;
    logic [ROB_W-1:0]         dec_dep_k;
    logic [ROB_W-1:0]         dec_rob_id;
    logic [31:0]              dec_tja;
    logic [31:0]              dec_fja;

    // common data bus broadcast channels, channel c at [c*W +: W]
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob_id;
    logic [NUM_CDB*32-1:0]    cdb_value;

    // station status
    logic                     full;
    logic [OCC_W-1:0]         occupancy;

    // issue port towards the ALU
    logic                     iss_valid;
    logic                     iss_ready;
    logic [4:0]               iss_op;
    logic [31:0]              iss_lhs;
    logic [31:0]              iss_rhs;
    logic [ROB_W-1:0]         iss_rob_id;
    logic [31:0]              iss_tja;
    logic [31:0]              iss_fja;

    modport master (
        output dec_valid, dec_type, dec_vj, dec_vk, dec_has_dep_j, dec_has_dep_k,
               dec_dep_j, dec_dep_k, dec_rob_id, dec_tja, dec_fja,
               cdb_valid, cdb_rob_id, cdb_value, iss_ready,
        input  full, occupancy, iss_valid, iss_op, iss_lhs, iss_rhs,
               iss_rob_id, iss_tja, iss_fja
    );

    modport slave (
        input  dec_valid, dec_type, dec_vj, dec_vk, dec_has_dep_j, dec_has_dep_k,
               dec_dep_j, dec_dep_k, dec_rob_id, dec_tja, dec_fja,
               cdb_valid, cdb_rob_id, cdb_value, iss_ready,
        output full, occupancy, iss_valid, iss_op, iss_lhs, iss_rhs,
               iss_rob_id, iss_tja, iss_fja
    );
endinterface

// File: rtl/rs_multi.sv
// rs_multi: parametrised reservation station. Holds decoded ALU/branch ops
// until both operands are known, snoops NUM_CDB broadcast channels for
// wake-up and dispatches one ready entry per cycle into a registered
// valid/ready issue port.
//
// Optional feature macro: RS_AGE_ORDER_EN
//   defined   - each entry carries a saturating age counter, dispatch picks
//               the oldest ready entry (lowest index breaks ties)
//   undefined - dispatch picks the lowest-index ready entry
module rs_multi #(
    parameter int DEPTH   = 8,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear,
    rs_multi_if.slave    bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    // entry storage
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] dj_q;
    logic [DEPTH-1:0] dk_q;
    logic [4:0]       type_q [DEPTH];
    logic [31:0]      vj_q   [DEPTH];
    logic [31:0]      vk_q   [DEPTH];
    logic [ROB_W-1:0] qj_q   [DEPTH];
    logic [ROB_W-1:0] qk_q   [DEPTH];
    logic [ROB_W-1:0] rob_q  [DEPTH];
    logic [31:0]      tja_q  [DEPTH];
    logic [31:0]      fja_q  [DEPTH];
`ifdef RS_AGE_ORDER_EN
    localparam logic [IDX_W-1:0] AGE_MAX = '1;
    logic [IDX_W-1:0] age_q  [DEPTH];
`endif

    // issue register
    logic             iss_valid_q;
    logic [4:0]       iss_op_q;
    logic [31:0]      iss_lhs_q;
    logic [31:0]      iss_rhs_q;
    logic [ROB_W-1:0] iss_rob_q;
    logic [31:0]      iss_tja_q;
    logic [31:0]      iss_fja_q;

    // unpacked CDB channels
    logic [ROB_W-1:0] cdb_tag [NUM_CDB];
    logic [31:0]      cdb_val [NUM_CDB];

    // tag match results
    logic             dec_hit_j;
    logic             dec_hit_k;
    logic [31:0]      dec_val_j;
    logic [31:0]      dec_val_k;
    logic [DEPTH-1:0] wake_j;
    logic [DEPTH-1:0] wake_k;
    logic [31:0]      wake_val_j [DEPTH];
    logic [31:0]      wake_val_k [DEPTH];

    // bookkeeping and selection
    logic [OCC_W-1:0] occ_w;
    logic             full_w;
    logic [IDX_W-1:0] ins_slot;
    logic             ins_found;
    logic [DEPTH-1:0] ready_w;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             iss_free;
    logic             ins_fire;
    logic             disp_fire;

    // split the packed CDB buses into per-channel tag/value
    always_comb begin
        for (int c = 0; c < NUM_CDB; c++) begin
            cdb_tag[c] = bus.cdb_rob_id[c*ROB_W +: ROB_W];
            cdb_val[c] = bus.cdb_value[c*32 +: 32];
        end
    end

    // tag match against every valid channel; scanning high to low lets the
    // lowest channel index win when the same tag appears twice
    always_comb begin
        dec_hit_j = 1'b0;
        dec_hit_k = 1'b0;
        dec_val_j = '0;
        dec_val_k = '0;
        wake_j    = '0;
        wake_k    = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wake_val_j[e] = '0;
            wake_val_k[e] = '0;
        end
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (bus.cdb_valid[c]) begin
                if (cdb_tag[c] == bus.dec_dep_j) begin
                    dec_hit_j = 1'b1;
                    dec_val_j = cdb_val[c];
                end
                if (cdb_tag[c] == bus.dec_dep_k) begin
                    dec_hit_k = 1'b1;
                    dec_val_k = cdb_val[c];
                end
                for (int e = 0; e < DEPTH; e++) begin
                    if (cdb_tag[c] == qj_q[e]) begin
                        wake_j[e]     = 1'b1;
                        wake_val_j[e] = cdb_val[c];
                    end
                    if (cdb_tag[c] == qk_q[e]) begin
                        wake_k[e]     = 1'b1;
                        wake_val_k[e] = cdb_val[c];
                    end
                end
            end
        end
    end

    // occupancy count and lowest-index free slot, both from registered busy
    always_comb begin
        occ_w     = '0;
        ins_slot  = '0;
        ins_found = 1'b0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            occ_w = occ_w + OCC_W'(busy_q[e]);
            if (!busy_q[e]) begin
                ins_slot  = IDX_W'(e);
                ins_found = 1'b1;
            end
        end
        full_w = (occ_w == OCC_W'(DEPTH));
    end

    // pick the entry to dispatch among those with both operands present
    always_comb begin
        ready_w   = busy_q & ~dj_q & ~dk_q;
        sel_idx   = '0;
        sel_found = 1'b0;
`ifdef RS_AGE_ORDER_EN
        for (int e = 0; e < DEPTH; e++) begin
            if (ready_w[e] && (!sel_found || age_q[e] > age_q[sel_idx])) begin
                sel_idx   = IDX_W'(e);
                sel_found = 1'b1;
            end
        end
`else
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (ready_w[e]) begin
                sel_idx   = IDX_W'(e);
                sel_found = 1'b1;
            end
        end
`endif
        iss_free  = !iss_valid_q || bus.iss_ready;
        ins_fire  = rdy_in && !clear && bus.dec_valid && !full_w && ins_found;
        disp_fire = rdy_in && !clear && iss_free && sel_found;
    end

    // entry array: insert, wake-up, dispatch release and flush
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            dj_q   <= '0;
            dk_q   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                type_q[e] <= '0;
                vj_q[e]   <= '0;
                vk_q[e]   <= '0;
                qj_q[e]   <= '0;
                qk_q[e]   <= '0;
                rob_q[e]  <= '0;
                tja_q[e]  <= '0;
                fja_q[e]  <= '0;
`ifdef RS_AGE_ORDER_EN
                age_q[e]  <= '0;
`endif
            end
        end else if (rdy_in) begin
            if (clear) begin
                busy_q <= '0;
                dj_q   <= '0;
                dk_q   <= '0;
`ifdef RS_AGE_ORDER_EN
                for (int e = 0; e < DEPTH; e++) begin
                    age_q[e] <= '0;
                end
`endif
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (busy_q[e] && dj_q[e] && wake_j[e]) begin
                        vj_q[e] <= wake_val_j[e];
                        dj_q[e] <= 1'b0;
                    end
                    if (busy_q[e] && dk_q[e] && wake_k[e]) begin
                        vk_q[e] <= wake_val_k[e];
                        dk_q[e] <= 1'b0;
                    end
`ifdef RS_AGE_ORDER_EN
                    if (ins_fire && busy_q[e] && age_q[e] != AGE_MAX) begin
                        age_q[e] <= age_q[e] + 1'b1;
                    end
`endif
                end
                if (disp_fire) begin
                    busy_q[sel_idx] <= 1'b0;
                end
                // the insert slot is free, so it never collides with the
                // wake-up or dispatch updates above
                if (ins_fire) begin
                    busy_q[ins_slot] <= 1'b1;
                    type_q[ins_slot] <= bus.dec_type;
                    rob_q[ins_slot]  <= bus.dec_rob_id;
                    tja_q[ins_slot]  <= bus.dec_tja;
                    fja_q[ins_slot]  <= bus.dec_fja;
                    qj_q[ins_slot]   <= bus.dec_dep_j;
                    qk_q[ins_slot]   <= bus.dec_dep_k;
                    dj_q[ins_slot]   <= bus.dec_has_dep_j && !dec_hit_j;
                    dk_q[ins_slot]   <= bus.dec_has_dep_k && !dec_hit_k;
                    vj_q[ins_slot]   <= (bus.dec_has_dep_j && dec_hit_j) ? dec_val_j : bus.dec_vj;
                    vk_q[ins_slot]   <= (bus.dec_has_dep_k && dec_hit_k) ? dec_val_k : bus.dec_vk;
`ifdef RS_AGE_ORDER_EN
                    age_q[ins_slot]  <= '0;
`endif
                end
            end
        end
    end

    // issue register: loads on dispatch, drains on accept, holds otherwise
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_lhs_q   <= '0;
            iss_rhs_q   <= '0;
            iss_rob_q   <= '0;
            iss_tja_q   <= '0;
            iss_fja_q   <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                iss_valid_q <= 1'b0;
            end else if (disp_fire) begin
                iss_valid_q <= 1'b1;
                iss_op_q    <= type_q[sel_idx];
                iss_lhs_q   <= vj_q[sel_idx];
                iss_rhs_q   <= vk_q[sel_idx];
                iss_rob_q   <= rob_q[sel_idx];
                iss_tja_q   <= tja_q[sel_idx];
                iss_fja_q   <= fja_q[sel_idx];
            end else if (bus.iss_ready) begin
                iss_valid_q <= 1'b0;
            end
        end
    end

    assign bus.full       = full_w;
    assign bus.occupancy  = occ_w;
    assign bus.iss_valid  = iss_valid_q;
    assign bus.iss_op     = iss_op_q;
    assign bus.iss_lhs    = iss_lhs_q;
    assign bus.iss_rhs    = iss_rhs_q;
    assign bus.iss_rob_id = iss_rob_q;
    assign bus.iss_tja    = iss_tja_q;
    assign bus.iss_fja    = iss_fja_q;

endmodule
